op_sched: RTL and testbench

Loop scheduler between the command decoder and the compute engine. Captures one decoded layer command (op type, stride, kernel, sides, channels) and walks the output volume: output channel innermost, then output column, then output row. Presents one engine job per output point over a req/ack handshake, with the matching input-window base coordinates. Pulses `done` once the engine has drained the last job.

---
 rtl/op_sched_pkg.sv | 14 +
 rtl/nest_counter.sv | 38 +++
 rtl/op_sched.sv | 169 ++++++++++++++++
 tb/tb_op_sched.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/op_sched_pkg.sv
// Shared opcode encodings for the layer scheduler; these match the command word
// produced by the decoder.
package op_sched_pkg;

  localparam logic [2:0] OP_IDLE    = 3'b000;
  localparam logic [2:0] OP_CONV    = 3'b001;
  localparam logic [2:0] OP_MAXPOOL = 3'b100;
  localparam logic [2:0] OP_AVGPOOL = 3'b101;

  function automatic logic op_supported(input logic [2:0] op);
    return (op == OP_CONV) || (op == OP_MAXPOOL) || (op == OP_AVGPOOL);
  endfunction

endpackage

// File: rtl/nest_counter.sv
// Wrapping counter for one level of a loop nest; 'wrap' carries into the next
// outer level and 'count_next' lets the parent look one step ahead.
module nest_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] limit,
  output logic [W-1:0] count,
  output logic [W-1:0] count_next,
  output logic         wrap
);

  logic at_max;

  assign at_max = (count == (limit - W'(1)));
  assign wrap   = en && at_max;

  always_comb begin
    count_next = count;
    if (clr) begin
      count_next = '0;
    end else if (en) begin
      count_next = at_max ? '0 : (count + W'(1));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else begin
      count <= count_next;
    end
  end

endmodule

// File: rtl/op_sched.sv
// Layer loop scheduler: latches one command and issues one engine job per
// output point (channel innermost, then column, then row).
module op_sched
  import op_sched_pkg::*;
#(
  parameter int CH_W   = 16,
  parameter int SIDE_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        op_type,
  input  logic [3:0]        stride,
  input  logic [7:0]        kernel,
  input  logic [SIDE_W-1:0] o_side,
  input  logic [CH_W-1:0]   i_channel,
  input  logic [CH_W-1:0]   o_channel,
  output logic              eng_req,
  input  logic              eng_ack,
  input  logic              eng_idle,
  output logic [2:0]        job_op,
  output logic [7:0]        job_kernel,
  output logic [SIDE_W-1:0] job_x,
  output logic [SIDE_W-1:0] job_y,
  output logic [CH_W-1:0]   job_ch,
  output logic [SIDE_W-1:0] job_ix,
  output logic [SIDE_W-1:0] job_iy,
  output logic              job_last,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [31:0]       jobs_issued
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CHECK  = 3'd1,
    S_ISSUE  = 3'd2,
    S_DRAIN  = 3'd3,
    S_FINISH = 3'd4
  } state_t;

  state_t state, state_next;

  logic [3:0]        stride_r;
  logic [SIDE_W-1:0] side_r;
  logic [CH_W-1:0]   ich_r;
  logic [CH_W-1:0]   och_r;
  logic [CH_W-1:0]   lim;
  logic              reject;
  logic              load;
  logic              fire;
  logic              adv;
  logic [SIDE_W-1:0] step;

  logic [CH_W-1:0]   ch_n;
  logic [SIDE_W-1:0] x_n;
  logic [SIDE_W-1:0] y_n;
  logic              ch_wrap;
  logic              x_wrap;
  logic              y_wrap;

  // Pooling runs over the input channels; conv runs over the output channels.
  always_comb begin
    lim = '0;
    if (job_op == OP_CONV) begin
      lim = och_r;
    end else if ((job_op == OP_MAXPOOL) || (job_op == OP_AVGPOOL)) begin
      lim = ich_r;
    end
  end

  assign reject = !op_supported(job_op) || (side_r == '0) || (stride_r == '0) || (lim == '0);
  assign load   = (state == S_IDLE) && cmd_valid;
  assign fire   = (state == S_ISSUE) && eng_ack;
  assign adv    = fire && !job_last;
  assign step   = SIDE_W'(stride_r);

  assign cmd_ready = (state == S_IDLE);
  assign busy      = (state != S_IDLE);
  assign eng_req   = (state == S_ISSUE);

  nest_counter #(.W(CH_W)) u_ch (
    .clk(clk), .rst(rst), .clr(load), .en(adv), .limit(lim),
    .count(job_ch), .count_next(ch_n), .wrap(ch_wrap)
  );

  nest_counter #(.W(SIDE_W)) u_x (
    .clk(clk), .rst(rst), .clr(load), .en(ch_wrap), .limit(side_r),
    .count(job_x), .count_next(x_n), .wrap(x_wrap)
  );

  nest_counter #(.W(SIDE_W)) u_y (
    .clk(clk), .rst(rst), .clr(load), .en(x_wrap), .limit(side_r),
    .count(job_y), .count_next(y_n), .wrap(y_wrap)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      S_IDLE:   if (cmd_valid) state_next = S_CHECK;
      S_CHECK:  state_next = reject ? S_IDLE : S_ISSUE;
      S_ISSUE:  if (fire && job_last) state_next = S_DRAIN;
      S_DRAIN:  if (eng_idle) state_next = S_FINISH;
      S_FINISH: state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      job_op      <= '0;
      job_kernel  <= '0;
      stride_r    <= '0;
      side_r      <= '0;
      ich_r       <= '0;
      och_r       <= '0;
      job_ix      <= '0;
      job_iy      <= '0;
      job_last    <= 1'b0;
      jobs_issued <= '0;
      done        <= 1'b0;
      err         <= 1'b0;
    end else begin
      if (load) begin
        job_op      <= op_type;
        job_kernel  <= kernel;
        stride_r    <= stride;
        side_r      <= o_side;
        ich_r       <= i_channel;
        och_r       <= o_channel;
        job_ix      <= '0;
        job_iy      <= '0;
        job_last    <= 1'b0;
        jobs_issued <= '0;
      end
      // Counters sit at zero here, so the first job is last only for a 1x1x1 volume.
      if (state == S_CHECK) begin
        job_last <= (lim == CH_W'(1)) && (side_r == SIDE_W'(1));
      end
      if (ch_wrap) begin
        job_ix <= x_wrap ? '0 : (job_ix + step);
      end
      if (x_wrap) begin
        job_iy <= y_wrap ? '0 : (job_iy + step);
      end
      if (adv) begin
        job_last <= (ch_n == (lim - CH_W'(1))) &&
                    (x_n == (side_r - SIDE_W'(1))) &&
                    (y_n == (side_r - SIDE_W'(1)));
      end
      if (fire) begin
        jobs_issued <= jobs_issued + 32'd1;
      end
      err  <= (state == S_CHECK) && reject;
      done <= (state == S_FINISH);
    end
  end

endmodule

// File: tb/tb_op_sched.sv
// Bench for op_sched: expected jobs are queued when a command is sent and a
// negedge monitor pops and compares them on every accepted request.
module tb_op_sched;

  localparam int CH_W   = 16;
  localparam int SIDE_W = 8;
  localparam int JW     = 60;

  logic              clk;
  logic              rst;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [2:0]        op_type;
  logic [3:0]        stride;
  logic [7:0]        kernel;
  logic [SIDE_W-1:0] o_side;
  logic [CH_W-1:0]   i_channel;
  logic [CH_W-1:0]   o_channel;
  logic              eng_req;
  logic              eng_ack;
  logic              eng_idle;
  logic [2:0]        job_op;
  logic [7:0]        job_kernel;
  logic [SIDE_W-1:0] job_x;
  logic [SIDE_W-1:0] job_y;
  logic [CH_W-1:0]   job_ch;
  logic [SIDE_W-1:0] job_ix;
  logic [SIDE_W-1:0] job_iy;
  logic              job_last;
  logic              busy;
  logic              done;
  logic              err;
  logic [31:0]       jobs_issued;

  op_sched #(.CH_W(CH_W), .SIDE_W(SIDE_W)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .op_type(op_type), .stride(stride), .kernel(kernel), .o_side(o_side),
    .i_channel(i_channel), .o_channel(o_channel), .eng_req(eng_req),
    .eng_ack(eng_ack), .eng_idle(eng_idle), .job_op(job_op),
    .job_kernel(job_kernel), .job_x(job_x), .job_y(job_y), .job_ch(job_ch),
    .job_ix(job_ix), .job_iy(job_iy), .job_last(job_last), .busy(busy),
    .done(done), .err(err), .jobs_issued(jobs_issued)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;
  logic [JW-1:0] exp_q[$];

  logic ack_rand = 1'b0;
  logic ack_hold = 1'b1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [JW-1:0] pack(input logic [2:0] op, input logic [7:0] k,
                                         input logic [7:0] x, input logic [7:0] y,
                                         input logic [15:0] ch, input logic [7:0] ix,
                                         input logic [7:0] iy, input logic last);
    return {op, k, x, y, ch, ix, iy, last};
  endfunction

  logic [JW-1:0] dut_job;
  assign dut_job = pack(job_op, job_kernel, job_x, job_y, job_ch, job_ix, job_iy, job_last);

  // ---------------- driver tasks ----------------
  initial begin
    eng_ack = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      eng_ack = ack_rand ? ($urandom_range(0, 3) != 0) : ack_hold;
    end
  end

  task automatic push_jobs(input logic [2:0] op, input logic [7:0] k, input int side,
                           input int lim, input int st);
    for (int y = 0; y < side; y++)
      for (int x = 0; x < side; x++)
        for (int c = 0; c < lim; c++)
          exp_q.push_back(pack(op, k, 8'(x), 8'(y), 16'(c), 8'(x * st), 8'(y * st),
                               (c == lim - 1) && (x == side - 1) && (y == side - 1)));
  endtask

  task automatic send_cmd(input logic [2:0] op, input logic [3:0] st, input logic [7:0] k,
                          input logic [7:0] side, input logic [15:0] ich,
                          input logic [15:0] och, output int t0);
    @(posedge clk);
    #1;
    op_type   = op;
    stride    = st;
    kernel    = k;
    o_side    = side;
    i_channel = ich;
    o_channel = och;
    cmd_valid = 1'b1;
    t0        = cyc;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input string name, input int t0, input int exp_lat,
                           input int exp_jobs, input int budget);
    int got;
    got = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done) begin
        got = 1;
        break;
      end
    end
    if (got == 0) begin
      total++;
      bad++;
      $display("FAIL %s_timeout: done not seen, required within %0d cycles", name, budget);
    end else begin
      if (exp_lat >= 0) check({name, "_latency"}, 64'(cyc - t0), 64'(exp_lat));
      check({name, "_jobs_issued"}, 64'(jobs_issued), 64'(exp_jobs));
      check({name, "_jobs_left"}, 64'(exp_q.size()), 64'd0);
      @(negedge clk);
      check({name, "_done_width"}, 64'(done), 64'd0);
      check({name, "_ready_after"}, 64'(cmd_ready), 64'd1);
    end
  endtask

  task automatic expect_reject(input string name, input logic [2:0] op, input logic [3:0] st,
                               input logic [7:0] side, input logic [15:0] ich,
                               input logic [15:0] och);
    int t0;
    int req0;
    int got;
    req0 = req_cycles;
    got  = 0;
    send_cmd(op, st, 8'd3, side, ich, och, t0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (err) begin
        got = 1;
        break;
      end
    end
    if (got == 0) begin
      total++;
      bad++;
      $display("FAIL %s_err_timeout: err not seen, required within 10 cycles", name);
    end else begin
      check({name, "_err_latency"}, 64'(cyc - t0), 64'd2);
      check({name, "_no_req"}, 64'(req_cycles - req0), 64'd0);
      @(negedge clk);
      check({name, "_err_width"}, 64'(err), 64'd0);
      check({name, "_idle_busy"}, 64'(busy), 64'd0);
      check({name, "_idle_ready"}, 64'(cmd_ready), 64'd1);
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  int            req_cycles = 0;
  logic          held = 1'b0;
  logic [JW-1:0] held_job;

  always @(negedge clk) begin
    if (rst) begin
      held = 1'b0;
    end else begin
      if (eng_req) begin
        req_cycles++;
        if (held) check("hold_stable", 64'(dut_job), 64'(held_job));
        if (eng_ack) begin
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL extra_job: got %0h, required no job", dut_job);
          end else begin
            check("job", 64'(dut_job), 64'(exp_q.pop_front()));
          end
          held = 1'b0;
        end else begin
          held     = 1'b1;
          held_job = dut_job;
        end
      end else begin
        held = 1'b0;
      end
      if (done || err) check("done_err_exclusive", 64'(done && err), 64'd0);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, required finish before 2ms");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int t0;
    int got;
    rst       = 1'b1;
    cmd_valid = 1'b0;
    op_type   = '0;
    stride    = '0;
    kernel    = '0;
    o_side    = '0;
    i_channel = '0;
    o_channel = '0;
    eng_idle  = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_cmd_ready", 64'(cmd_ready), 64'd1);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_eng_req", 64'(eng_req), 64'd0);
    check("rst_done_err", 64'({done, err}), 64'd0);
    check("rst_jobs", 64'(jobs_issued), 64'd0);
    check("rst_job", 64'(dut_job), 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    // conv, full throughput: 12 jobs, done 16 cycles after the command
    push_jobs(3'b001, 8'd3, 2, 3, 2);
    send_cmd(3'b001, 4'd2, 8'd3, 8'd2, 16'd7, 16'd3, t0);
    wait_done("conv", t0, 16, 12, 60);

    // max-pool iterates over i_channel
    push_jobs(3'b100, 8'd2, 1, 2, 1);
    send_cmd(3'b100, 4'd1, 8'd2, 8'd1, 16'd2, 16'd9, t0);
    wait_done("maxpool", t0, 6, 2, 40);

    // avg-pool with stride 3: window bases step by 3
    push_jobs(3'b101, 8'd3, 2, 2, 3);
    send_cmd(3'b101, 4'd3, 8'd3, 8'd2, 16'd2, 16'd0, t0);
    wait_done("avgpool", t0, 12, 8, 60);

    // backpressure
    ack_rand = 1'b1;
    push_jobs(3'b001, 8'd3, 3, 2, 1);
    send_cmd(3'b001, 4'd1, 8'd3, 8'd3, 16'd1, 16'd2, t0);
    wait_done("backpressure", t0, -1, 18, 400);
    ack_rand = 1'b0;

    // rejects
    expect_reject("rej_op", 3'b010, 4'd1, 8'd2, 16'd2, 16'd2);
    expect_reject("rej_stride", 3'b001, 4'd0, 8'd2, 16'd2, 16'd2);
    expect_reject("rej_side", 3'b001, 4'd1, 8'd0, 16'd2, 16'd2);
    expect_reject("rej_chan", 3'b101, 4'd1, 8'd2, 16'd0, 16'd4);

    // drain: engine stays busy 5 cycles past the last ack
    eng_idle = 1'b0;
    push_jobs(3'b001, 8'd3, 2, 3, 2);
    send_cmd(3'b001, 4'd2, 8'd3, 8'd2, 16'd1, 16'd3, t0);
    got = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (eng_req && eng_ack && job_last) begin
        got = 1;
        break;
      end
    end
    check("drain_last_seen", 64'(got), 64'd1);
    repeat (6) @(posedge clk);
    #1 eng_idle = 1'b1;
    wait_done("drain", t0, 21, 12, 40);

    // reset in the middle of a layer
    push_jobs(3'b001, 8'd3, 2, 3, 2);
    send_cmd(3'b001, 4'd2, 8'd3, 8'd2, 16'd1, 16'd3, t0);
    got = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (jobs_issued == 32'd4) begin
        got = 1;
        break;
      end
    end
    check("midrst_reached_job4", 64'(got), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_eng_req", 64'(eng_req), 64'd0);
    check("midrst_jobs", 64'(jobs_issued), 64'd0);
    check("midrst_done", 64'(done), 64'd0);
    rst = 1'b0;
    exp_q.delete();
    push_jobs(3'b001, 8'd5, 1, 2, 1);
    send_cmd(3'b001, 4'd1, 8'd5, 8'd1, 16'd4, 16'd2, t0);
    wait_done("after_rst", t0, 6, 2, 40);

    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
